// File: rtl/dro_seq_pkg.sv
// Shared types and default sizing for the DRO cell sequencer.
package dro_seq_pkg;

  localparam int unsigned SEP_W_DEF   = 4;
  localparam int unsigned OUT_LAT_DEF = 3;
  localparam int unsigned VIOL_W_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSetGuard = 2'd1,
    StReadWait = 2'd2,
    StRstGuard = 2'd3
  } dro_state_e;

endpackage

// File: rtl/dro_guard_timer.sv
// Loadable down-counter shared by the guard intervals and the readout window.
module dro_guard_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load wins over tick; the count holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/dro_sequencer.sv
// Pulse sequencer for a destructive-readout cell: set/reset pulses, guard spacing, read capture.
module dro_sequencer
  import dro_seq_pkg::*;
#(
  parameter int unsigned SEP_W   = SEP_W_DEF,
  parameter int unsigned OUT_LAT = OUT_LAT_DEF,
  parameter int unsigned VIOL_W  = VIOL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [SEP_W-1:0]  min_sr,
  input  logic [SEP_W-1:0]  min_rs,
  input  logic              dro_out,
  output logic              dro_set,
  output logic              dro_reset,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic              rd_data,
  output logic              busy,
  output logic [VIOL_W-1:0] spurious_cnt
);

  dro_state_e state_q, state_d;

  logic             cap_q, cap_d;
  logic             set_d, pulse_d, valid_d, data_d;
  logic [VIOL_W-1:0] spur_d;

  logic             tmr_load, tmr_tick, tmr_zero;
  logic [SEP_W-1:0] tmr_load_val, tmr_value;

  dro_guard_timer #(
    .W(SEP_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    set_d        = 1'b0;
    pulse_d      = 1'b0;
    valid_d      = 1'b0;
    data_d       = rd_data;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_tick     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Reads take priority; a concurrent write stays pending until a later idle cycle.
        if (rd_req) begin
          pulse_d      = 1'b1;
          cap_d        = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = SEP_W'(OUT_LAT);
          state_d      = StReadWait;
        end else if (wr_req) begin
          set_d        = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = min_sr;
          state_d      = (min_sr == '0) ? StIdle : StSetGuard;
        end
      end
      StSetGuard, StRstGuard: begin
        tmr_tick = 1'b1;
        if (tmr_zero) begin
          state_d = StIdle;
        end
      end
      StReadWait: begin
        tmr_tick = 1'b1;
        cap_d    = cap_q | dro_out;
        // Window spans OUT_LAT cycles starting with the reset pulse itself.
        if (tmr_value == SEP_W'(1)) begin
          valid_d      = 1'b1;
          data_d       = cap_q | dro_out;
          tmr_load     = 1'b1;
          tmr_load_val = min_rs;
          state_d      = (min_rs == '0) ? StIdle : StRstGuard;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    spur_d = spurious_cnt;
    if ((state_q != StReadWait) && dro_out && (spurious_cnt != '1)) begin
      spur_d = spurious_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cap_q        <= 1'b0;
      dro_set      <= 1'b0;
      dro_reset    <= 1'b0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= 1'b0;
      busy         <= 1'b0;
      spurious_cnt <= '0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      dro_set      <= set_d;
      dro_reset    <= pulse_d;
      wr_ack       <= set_d;
      rd_ack       <= pulse_d;
      rd_valid     <= valid_d;
      rd_data      <= data_d;
      busy         <= (state_d != StIdle);
      spurious_cnt <= spur_d;
    end
  end

endmodule

// File: doc/dro_sequencer.md
DRO_SEQUENCER -- requirements
Module: dro_sequencer

Interface
REQ-001 Parameter SEP_W, default 4, width of guard-interval config fields.
REQ-002 Parameter OUT_LAT, default 3, cycles after the reset pulse during which dro_out is sampled as read data (1..2^SEP_W-1).
REQ-003 Parameter VIOL_W, default 8, width of the spurious-output counter.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_req  in  1  request a set pulse (store '1'); held until wr_ack.
REQ-007 rd_req  in  1  request a destructive readout (reset pulse); held until rd_ack.
REQ-008 min_sr  in  SEP_W  minimum idle cycles after a set pulse before any next pulse.
REQ-009 min_rs  in  SEP_W  minimum idle cycles after a read completes before any next pulse.
REQ-010 dro_out  in  1  DRO cell output.
REQ-011 dro_set  out  1  set pulse to DRO, 1 cycle wide.
REQ-012 dro_reset  out  1  reset/readout pulse to DRO, 1 cycle wide.
REQ-013 wr_ack / rd_ack  out  1 each  1-cycle acknowledge, coincident with the issued pulse.
REQ-014 rd_valid  out  1  1-cycle strobe, read result available.
REQ-015 rd_data  out  1  read result, valid when rd_valid is high, held otherwise.
REQ-016 busy  out  1  high whenever state != IDLE.
REQ-017 spurious_cnt  out  VIOL_W  saturating count of unexpected dro_out cycles.

Function
REQ-018 All outputs SHALL be registered; a request sampled in IDLE at edge k SHALL produce pulse+ack in the cycle after edge k.
REQ-019 FSM states SHALL be IDLE, SET_GUARD, READ_WAIT, RST_GUARD.
REQ-020 IDLE with rd_req SHALL issue dro_reset+rd_ack, load counter with OUT_LAT, and enter READ_WAIT.
REQ-021 IDLE with wr_req only SHALL issue dro_set+wr_ack, load counter with min_sr, and enter SET_GUARD, or stay in IDLE if min_sr==0.
REQ-022 Simultaneous rd_req and wr_req in IDLE SHALL serve read first; write is served on a later IDLE cycle.
REQ-023 SET_GUARD and RST_GUARD SHALL decrement the counter each cycle and return to IDLE on the cycle the counter reaches 0; requests are not acked there.
REQ-024 min_sr/min_rs SHALL be sampled only at load time; changes mid-guard have no effect on the running interval.
REQ-025 READ_WAIT SHALL OR dro_out into a capture bit, cleared on entry, over exactly OUT_LAT cycles.
REQ-026 At READ_WAIT end, rd_valid SHALL be high for 1 cycle with rd_data=capture bit; the counter loads min_rs, then RST_GUARD, or IDLE if min_rs==0.
REQ-027 dro_out high in any state other than READ_WAIT SHALL increment spurious_cnt by 1 per cycle, saturating at 2^VIOL_W-1, never wrapping.
REQ-028 dro_set and dro_reset SHALL never be high in the same cycle; at most one pulse per cycle.
REQ-029 Minimum spacing SHALL be min_sr+1 cycles from set to next pulse, and OUT_LAT+min_rs+1 cycles from reset to next pulse.

Reset
REQ-030 rst SHALL force state IDLE, counter 0, capture 0, and all outputs 0, including spurious_cnt and rd_data.
REQ-031 rst asserted mid-guard or mid-read SHALL abort without emitting rd_valid; the first request after deassertion is served from IDLE.

Structure
REQ-032 Package dro_seq_pkg SHALL hold the state enum typedef and default values of SEP_W, OUT_LAT, VIOL_W.
REQ-033 The shared countdown SHALL be one sub-module dro_guard_timer (load, value, tick, zero flag), instantiated once.

Verification
REQ-034 min_sr=2, wr_req held from cycle 0 -> dro_set+wr_ack at cycle 1, busy cycles 1-3, IDLE at cycle 4.
REQ-035 wr_req and rd_req both high in IDLE, min_sr=min_rs=0 -> dro_reset first, dro_set exactly OUT_LAT+1 cycles later.
REQ-036 Set, then read with dro_out pulsed 2 cycles after dro_reset, OUT_LAT=3 -> rd_valid=1, rd_data=1; repeat read with no dro_out pulse -> rd_data=0.
REQ-037 VIOL_W=2, dro_out held high 6 cycles in IDLE -> spurious_cnt reads 3 and stays at 3.
REQ-038 rst during READ_WAIT -> no rd_valid, all outputs 0 next cycle, and a subsequent wr_req is acked one cycle after being sampled.
